// File: rtl/relin_accum_stream.sv
// ============================================================================
// Module   : relin_accum_stream
// Brief    : Streaming key-switch accumulator. It sums per-digit partial-product
//            tiles mod Q, adds the base ciphertext tile on the last digit, and
//            emits finished tiles.
// Option   : RELIN_ACCUM_RANGE_CHECK_EN enables input range checking and err_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module relin_accum_stream #(
    parameter int          BIT_WIDTH  = 32,
    parameter int          TILE_N     = 4,
    parameter int          DEGREE_N   = 16,
    parameter int          NUM_DIGITS = 8,
    parameter int          NUM_CH     = 2,
    parameter int unsigned Q          = 132120577
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      valid_i,
    output logic                                      ready_o,
    input  logic [NUM_CH*TILE_N*BIT_WIDTH-1:0]        pp_i,
    input  logic [NUM_CH*TILE_N*BIT_WIDTH-1:0]        base_i,
    output logic                                      valid_o,
    input  logic                                      ready_i,
    output logic [NUM_CH*TILE_N*BIT_WIDTH-1:0]        coeff_o,
    output logic [((DEGREE_N/TILE_N) > 1 ? $clog2(DEGREE_N/TILE_N) : 1)-1:0] tile_idx_o,
    output logic                                      last_o,
    output logic                                      done_o,
    output logic                                      err_o
);

    localparam int NUM_TILES = DEGREE_N / TILE_N;
    localparam int TW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int DW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int NL        = NUM_CH * TILE_N;
    localparam int VW        = NL * BIT_WIDTH;

    localparam logic [BIT_WIDTH:0] c_q_ext     = (BIT_WIDTH+1)'(Q);
    localparam logic [TW-1:0]      c_last_tile = TW'(NUM_TILES - 1);
    localparam logic [DW-1:0]      c_last_dig  = DW'(NUM_DIGITS - 1);

    function automatic logic [BIT_WIDTH-1:0] modadd(input logic [BIT_WIDTH-1:0] a,
                                                    input logic [BIT_WIDTH-1:0] b);
        logic [BIT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= c_q_ext)
            s = s - c_q_ext;
        return s[BIT_WIDTH-1:0];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tile_cnt;
    logic [DW-1:0]   r_digit_cnt;
    logic [VW-1:0]   r_acc [NUM_TILES];
    logic [VW-1:0]   r_coeff;
    logic            r_valid;
    logic [TW-1:0]   r_tile_idx;
    logic            r_last;
    logic            r_done;

    logic            w_final_beat;
    logic            w_first_digit;
    logic            w_tile_wrap;
    logic            w_accept;
    logic [VW-1:0]   w_pp_use;
    logic [VW-1:0]   w_base_use;
    logic [VW-1:0]   w_acc_rd;
    logic [VW-1:0]   w_acc_next;
    logic [VW-1:0]   w_final;

    // A single-digit stream is final from its very first beat, even in IDLE.
    assign w_final_beat  = (r_state == S_FINAL) || (NUM_DIGITS == 1);
    assign w_first_digit = (r_digit_cnt == '0);
    assign w_tile_wrap   = (r_tile_cnt == c_last_tile);
    assign ready_o       = !rst && (!w_final_beat || !r_valid || ready_i);
    assign w_accept      = valid_i && ready_o;
    assign w_acc_rd      = r_acc[r_tile_cnt];

`ifdef RELIN_ACCUM_RANGE_CHECK_EN
    localparam logic [BIT_WIDTH-1:0] c_q_bw = BIT_WIDTH'(Q);

    logic w_range_hit;
    logic r_err;

    always_comb begin
        w_pp_use    = pp_i;
        w_base_use  = base_i;
        w_range_hit = 1'b0;
        for (int l = 0; l < NL; l++) begin
            if (pp_i[l*BIT_WIDTH +: BIT_WIDTH] >= c_q_bw) begin
                w_pp_use[l*BIT_WIDTH +: BIT_WIDTH] = pp_i[l*BIT_WIDTH +: BIT_WIDTH] - c_q_bw;
                w_range_hit = 1'b1;
            end
            if (base_i[l*BIT_WIDTH +: BIT_WIDTH] >= c_q_bw) begin
                w_base_use[l*BIT_WIDTH +: BIT_WIDTH] = base_i[l*BIT_WIDTH +: BIT_WIDTH] - c_q_bw;
                if (w_final_beat)
                    w_range_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_accept && w_range_hit)
            r_err <= 1'b1;
    end

    assign err_o = r_err;
`else
    assign w_pp_use   = pp_i;
    assign w_base_use = base_i;
    assign err_o      = 1'b0;
`endif

    always_comb begin
        w_acc_next = '0;
        for (int l = 0; l < NL; l++) begin
            w_acc_next[l*BIT_WIDTH +: BIT_WIDTH] = w_first_digit ?
                w_pp_use[l*BIT_WIDTH +: BIT_WIDTH] :
                modadd(w_acc_rd[l*BIT_WIDTH +: BIT_WIDTH], w_pp_use[l*BIT_WIDTH +: BIT_WIDTH]);
        end
    end

    generate
        if (NUM_DIGITS == 1) begin : g_single_digit
            always_comb begin
                w_final = '0;
                for (int l = 0; l < NL; l++)
                    w_final[l*BIT_WIDTH +: BIT_WIDTH] =
                        modadd(w_pp_use[l*BIT_WIDTH +: BIT_WIDTH], w_base_use[l*BIT_WIDTH +: BIT_WIDTH]);
            end
        end else begin : g_multi_digit
            always_comb begin
                w_final = '0;
                for (int l = 0; l < NL; l++)
                    w_final[l*BIT_WIDTH +: BIT_WIDTH] =
                        modadd(modadd(w_acc_rd[l*BIT_WIDTH +: BIT_WIDTH], w_pp_use[l*BIT_WIDTH +: BIT_WIDTH]),
                               w_base_use[l*BIT_WIDTH +: BIT_WIDTH]);
            end
        end
    endgenerate

    // Accumulator storage carries no reset; digit 0 always overwrites it.
    always_ff @(posedge clk) begin
        if (w_accept && !w_final_beat)
            r_acc[r_tile_cnt] <= w_acc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tile_cnt  <= '0;
            r_digit_cnt <= '0;
            r_coeff     <= '0;
            r_valid     <= 1'b0;
            r_tile_idx  <= '0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= r_valid && ready_i && r_last;

            if (w_accept && w_final_beat) begin
                r_coeff    <= w_final;
                r_valid    <= 1'b1;
                r_tile_idx <= r_tile_cnt;
                r_last     <= w_tile_wrap;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end

            if (w_accept) begin
                if (w_tile_wrap) begin
                    r_tile_cnt <= '0;
                    if (w_final_beat) begin
                        r_digit_cnt <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_digit_cnt <= r_digit_cnt + DW'(1);
                        r_state     <= (r_digit_cnt + DW'(1) == c_last_dig) ? S_FINAL : S_ACCUM;
                    end
                end else begin
                    r_tile_cnt <= r_tile_cnt + TW'(1);
                    r_state    <= w_final_beat ? S_FINAL : S_ACCUM;
                end
            end
        end
    end

    assign valid_o    = r_valid;
    assign coeff_o    = r_coeff;
    assign tile_idx_o = r_tile_idx;
    assign last_o     = r_last;
    assign done_o     = r_done;

endmodule

`default_nettype wire
